// File: rtl/method_call_initiator_if.sv
// rtl/method_call_initiator_if.sv - generated-method handshake between initiator and callee
interface method_call_initiator_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  m_req;
  logic                  m_busy;
  logic [DATA_WIDTH-1:0] m_return;

  modport master (output m_req, input m_busy, input m_return);
  modport slave  (input m_req, output m_busy, output m_return);
endinterface

// File: rtl/method_call_initiator.sv
// rtl/method_call_initiator.sv - issues one method call per start and checks its return value
module method_call_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 32,
  parameter int ACK_WAIT   = 4,
  parameter int TIMEOUT    = 10000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [DATA_WIDTH-1:0]  expected,
  input  logic [DATA_WIDTH-1:0]  mask,
  method_call_initiator_if.master m,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic                   timeout,
  output logic [DATA_WIDTH-1:0]  result,
  output logic [CNT_WIDTH-1:0]   cycles
);

  typedef enum logic [2:0] {IDLE, WAIT_IDLE, REQ, RUN, CHECK} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [DATA_WIDTH-1:0] mask_q;
  logic [CNT_WIDTH-1:0]  tcnt;
  logic [CNT_WIDTH-1:0]  lcnt;
  logic [7:0]            acnt;

  logic [CNT_WIDTH-1:0]  tcnt_inc;
  logic [CNT_WIDTH-1:0]  lcnt_inc;
  logic                  t_expire;
  logic                  ack_expire;
  logic                  ret_match;

  always_comb begin
    tcnt_inc   = (&tcnt) ? tcnt : tcnt + CNT_WIDTH'(1);
    lcnt_inc   = (&lcnt) ? lcnt : lcnt + CNT_WIDTH'(1);
    t_expire   = tcnt_inc >= CNT_WIDTH'(TIMEOUT);
    ack_expire = ({1'b0, acnt} + 9'd1) >= 9'(ACK_WAIT);
    ret_match  = ((m.m_return ^ exp_q) & mask_q) == '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      m.m_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      fail    <= 1'b0;
      timeout <= 1'b0;
      result  <= '0;
      cycles  <= '0;
      exp_q   <= '0;
      mask_q  <= '0;
      tcnt    <= '0;
      lcnt    <= '0;
      acnt    <= '0;
    end else begin
      done <= 1'b0;
      // The overall timeout is checked first so it wins over a same-cycle m_busy edge.
      if ((state == WAIT_IDLE || state == REQ || state == RUN) && t_expire) begin
        tcnt    <= tcnt_inc;
        m.m_req <= 1'b0;
        timeout <= 1'b1;
        pass    <= 1'b0;
        fail    <= 1'b0;
        result  <= m.m_return;
        cycles  <= lcnt;
        done    <= 1'b1;
        state   <= CHECK;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              exp_q   <= expected;
              mask_q  <= mask;
              pass    <= 1'b0;
              fail    <= 1'b0;
              timeout <= 1'b0;
              tcnt    <= '0;
              lcnt    <= '0;
              acnt    <= '0;
              busy    <= 1'b1;
              if (m.m_busy) begin
                state <= WAIT_IDLE;
              end else begin
                state   <= REQ;
                m.m_req <= 1'b1;
                lcnt    <= CNT_WIDTH'(1);
              end
            end
          end
          WAIT_IDLE: begin
            tcnt <= tcnt_inc;
            if (!m.m_busy) begin
              state   <= REQ;
              m.m_req <= 1'b1;
              lcnt    <= CNT_WIDTH'(1);
              acnt    <= '0;
            end
          end
          REQ: begin
            tcnt <= tcnt_inc;
            if (m.m_busy) begin
              // lcnt holds across the ack edge so cycles spans first request to last busy cycle.
              state   <= RUN;
              m.m_req <= 1'b0;
            end else if (ack_expire) begin
              m.m_req <= 1'b0;
              timeout <= 1'b1;
              pass    <= 1'b0;
              fail    <= 1'b0;
              result  <= m.m_return;
              cycles  <= lcnt;
              done    <= 1'b1;
              state   <= CHECK;
            end else begin
              acnt <= acnt + 8'd1;
              lcnt <= lcnt_inc;
            end
          end
          RUN: begin
            tcnt <= tcnt_inc;
            if (!m.m_busy) begin
              result <= m.m_return;
              cycles <= lcnt;
              pass   <= ret_match;
              fail   <= !ret_match;
              done   <= 1'b1;
              state  <= CHECK;
            end else begin
              lcnt <= lcnt_inc;
            end
          end
          CHECK: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            state   <= IDLE;
            m.m_req <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_method_call_initiator.sv
// tb/tb_method_call_initiator.sv - randomized self-checking bench with a behavioural callee
module tb_method_call_initiator;

  localparam int DW       = 32;
  localparam int CW       = 32;
  localparam int ACK_WAIT = 4;
  localparam int TIMEOUT  = 50;

  logic          clk;
  logic          reset;
  logic          start;
  logic [DW-1:0] expected;
  logic [DW-1:0] mask;
  logic          busy;
  logic          done;
  logic          pass;
  logic          fail;
  logic          timeout;
  logic [DW-1:0] result;
  logic [CW-1:0] cycles;

  method_call_initiator_if #(.DATA_WIDTH(DW)) mif ();

  method_call_initiator #(
    .DATA_WIDTH(DW), .CNT_WIDTH(CW), .ACK_WAIT(ACK_WAIT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .expected(expected), .mask(mask),
    .m(mif), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .result(result), .cycles(cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Callee configuration: cfg_pre busy cycles before the call, m_busy rises on the
  // (cfg_d+1)-th m_req cycle, stays high cfg_k cycles (0 = forever).
  int            cfg_d, cfg_k, cfg_pre;
  logic [DW-1:0] cfg_ret;
  int            arm_id = 0;

  int mreq_tot = 0;
  int done_tot = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int arm_seen, ph, reqc, bc, prec;
    arm_seen = 0; ph = 2; reqc = 0; bc = 0; prec = 0;
    mif.m_busy   = 1'b0;
    mif.m_return = '0;
    forever begin
      @(posedge clk);
      #1;
      if (arm_id != arm_seen) begin
        arm_seen = arm_id; ph = 0; reqc = 0; bc = 0; prec = cfg_pre;
        mif.m_return = cfg_ret;
      end
      if (prec > 0) begin
        mif.m_busy = 1'b1;
        prec--;
      end else begin
        if (ph == 0 && mif.m_req) begin
          reqc++;
          if (reqc == cfg_d + 1) ph = 1;
        end
        if (ph == 1) begin
          if (cfg_k == 0 || bc < cfg_k) begin
            mif.m_busy = 1'b1;
            bc++;
          end else begin
            mif.m_busy = 1'b0;
            ph = 2;
          end
        end else begin
          mif.m_busy = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mif.m_req) mreq_tot++;
    if (done) done_tot++;
  end

  task automatic arm(input int d, input int k, input int pre, input logic [DW-1:0] ret);
    @(negedge clk); #1;
    cfg_d = d; cfg_k = k; cfg_pre = pre; cfg_ret = ret;
    arm_id++;
    @(negedge clk); #1;
  endtask

  task automatic do_call(input string tag, input int d, input int k, input int pre,
                         input logic [DW-1:0] ret, input logic [DW-1:0] ex,
                         input logic [DW-1:0] mk, input bit extra_start);
    int   n, mreq0, done0, exp_lat, exp_mreq, exp_cyc;
    logic exp_to, exp_pass;
    arm(d, k, pre, ret);
    mreq0 = mreq_tot;
    done0 = done_tot;
    start = 1'b1; expected = ex; mask = mk;
    @(negedge clk);
    start = 1'b0; expected = ~ex; mask = $urandom;
    n = 1;
    while (!done && n < 400) begin
      if (extra_start) start = (n == 4);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    if (k == 0) begin
      exp_to = 1'b1; exp_pass = 1'b0; exp_lat = TIMEOUT + 1; exp_mreq = d + 1; exp_cyc = -1;
    end else if (d + 1 > ACK_WAIT) begin
      exp_to = 1'b1; exp_pass = 1'b0; exp_lat = pre + ACK_WAIT + 1;
      exp_mreq = ACK_WAIT; exp_cyc = ACK_WAIT;
    end else begin
      exp_to = 1'b0; exp_pass = ((ret ^ ex) & mk) == '0;
      exp_lat = pre + d + k + 2; exp_mreq = d + 1; exp_cyc = d + k;
    end
    check({tag, ".done"}, done, 1'b1);
    check({tag, ".latency"}, n, exp_lat);
    check({tag, ".timeout"}, timeout, exp_to);
    check({tag, ".pass"}, pass, exp_pass);
    check({tag, ".fail"}, fail, !exp_to && !exp_pass);
    check({tag, ".result"}, result, ret);
    if (exp_cyc >= 0) check({tag, ".cycles"}, cycles, exp_cyc);
    check({tag, ".busy_in_check"}, busy, 1'b1);
    check({tag, ".m_req_at_done"}, mif.m_req, 1'b0);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, done, 1'b0);
    check({tag, ".busy_idle"}, busy, 1'b0);
    check({tag, ".pass_held"}, pass, exp_pass);
    #1;
    check({tag, ".done_pulses"}, done_tot - done0, 1);
    check({tag, ".m_req_cycles"}, mreq_tot - mreq0, exp_mreq);
  endtask

  initial begin
    int            d, k, pre;
    logic [DW-1:0] ex, mk, ret;
    int            done0;
    reset = 1'b1; start = 1'b0; expected = '0; mask = '0;
    cfg_d = 0; cfg_k = 1; cfg_pre = 0; cfg_ret = '0;
    repeat (3) @(negedge clk);
    check("reset.m_req", mif.m_req, 1'b0);
    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.flags", {pass, fail, timeout}, 3'b000);
    check("reset.result", result, '0);
    check("reset.cycles", cycles, '0);
    reset = 1'b0;

    do_call("basic", 1, 5, 0, 32'h1, 32'h1, 32'hFFFF_FFFF, 1'b0);
    do_call("mismatch", 1, 5, 0, 32'hA5, 32'hA4, 32'hFFFF_FFFF, 1'b0);
    do_call("masked", 1, 5, 0, 32'hA5, 32'hA4, 32'hFFFF_FFFE, 1'b0);
    do_call("wait_idle", 1, 5, 7, 32'h1234, 32'h1234, 32'hFFFF_FFFF, 1'b0);
    do_call("ack_timeout", 100, 5, 0, 32'hDEAD, 32'hDEAD, 32'hFFFF_FFFF, 1'b0);
    do_call("run_timeout", 1, 0, 0, 32'hBEEF, 32'hBEEF, 32'hFFFF_FFFF, 1'b0);
    do_call("extra_start", 1, 6, 0, 32'h55, 32'h55, 32'hFFFF_FFFF, 1'b1);

    arm(1, 20, 0, 32'h77);
    done0 = done_tot;
    start = 1'b1; expected = 32'h77; mask = '1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset.m_req", mif.m_req, 1'b0);
    check("midreset.busy", busy, 1'b0);
    check("midreset.done", done, 1'b0);
    check("midreset.flags", {pass, fail, timeout}, 3'b000);
    check("midreset.result", result, '0);
    check("midreset.cycles", cycles, '0);
    repeat (30) @(negedge clk);
    #1;
    check("midreset.no_done", done_tot - done0, 0);
    do_call("after_reset", 2, 3, 0, 32'h9, 32'h9, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 25; i++) begin
      d   = $urandom_range(0, 5);
      k   = $urandom_range(1, 8);
      pre = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      ex  = $urandom;
      mk  = $urandom;
      ret = $urandom_range(0, 1) ? (ex ^ ($urandom & ~mk)) : (ex ^ $urandom);
      do_call($sformatf("rand%0d", i), d, k, pre, ret, ex, mk, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/method_call_initiator.md
Name: method_call_initiator

Overview:
- Synthesizable initiator for the generated-method handshake (`<m>_req` in, `<m>_busy` / `<m>_return` out on the callee).
- Issues one call per `start` and waits for completion.
- Captures the return value, compares it with an expected value under a mask, and reports pass/fail/timeout plus the call latency.
- Placed beside a generated module to self-test methods in hardware, replacing the open-loop `req`-high stimulus of simulation benches.

Parameters:
- DATA_WIDTH, 32, width of method return, expected value and mask.
- CNT_WIDTH, 32, width of the latency counter.
- ACK_WAIT, 4, max cycles `m_req` is held waiting for `m_busy` to rise; range 1..255.
- TIMEOUT, 10000, max cycles from `start` acceptance to completion before abort; must be < 2^CNT_WIDTH.

Ports:
- clk  in  1  sole clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request one call; sampled only in IDLE.
- expected  in  DATA_WIDTH  expected return; latched on `start` acceptance.
- mask  in  DATA_WIDTH  compare mask; latched on `start` acceptance.
- m_req  out  1  method request to callee.
- m_busy  in  1  callee busy.
- m_return  in  DATA_WIDTH  callee return value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a call finishes (any outcome).
- pass  out  1  result of last call; held until next accepted `start`.
- fail  out  1  compare mismatch on last call; held.
- timeout  out  1  last call aborted (ack or overall timeout); held.
- result  out  DATA_WIDTH  captured `m_return`; held.
- cycles  out  CNT_WIDTH  latency of last call; held.

Behaviour:
- Reset values: `m_req`, `busy`, `done`, `pass`, `fail` and `timeout` are 0; `result` and `cycles` are 0; state is IDLE.
- Reset mid-operation: `m_req` is 0 from the first edge with `reset` high. No `done` pulse is issued and held results are cleared.
- States are IDLE, WAIT_IDLE, REQ, RUN, CHECK.
- IDLE:
  - On `start`=1, latch `expected` and `mask`, clear `pass`/`fail`/`timeout`, and zero the timeout counter.
  - Go to WAIT_IDLE if `m_busy`=1 at that edge, else REQ.
- WAIT_IDLE:
  - `m_req`=0; stay until `m_busy`=0, then REQ.
  - The latency counter does not run here; the timeout counter does.
- REQ:
  - `m_req`=1 registered, high in every REQ cycle; the latency counter starts at 1 on the first REQ cycle.
  - On `m_busy`=1, go to RUN; `m_req` is 0 from the next cycle.
  - If `m_busy` has not risen after ACK_WAIT REQ cycles, set `timeout`=1 and go to CHECK with compare suppressed.
- RUN:
  - `m_req`=0; the latency counter increments each cycle.
  - On `m_busy`=0, capture `m_return` into `result`, store the latency counter into `cycles`, and go to CHECK.
- Timeout:
  - The timeout counter increments in every non-IDLE cycle.
  - At TIMEOUT, from any of WAIT_IDLE/REQ/RUN, set `timeout`=1, drop `m_req`, and go to CHECK.
  - On timeout, `result` is the value sampled at that edge and `cycles` is the saturated counter value.
- CHECK (one cycle):
  - `done`=1.
  - If `timeout`=0: `pass` = ((`result` ^ expected) & mask) == 0, and `fail` = !`pass`.
  - If `timeout`=1: `pass`=0, `fail`=0.
  - Return to IDLE; `start` is not accepted in CHECK.
- Simultaneous events: timeout takes priority over a same-cycle `m_busy` edge.
- Counters saturate and never wrap.
- `start` outside IDLE is ignored, not queued.
- Latency definition: a callee raising `m_busy` the cycle after `m_req`, and dropping it after K busy cycles, gives `cycles` = K+1.

Test Plan:
- Responder with `m_busy` rising 1 cycle after `m_req`, high 5 cycles, `m_return`=1; `expected`=1, `mask`=FFFFFFFF -> one `done` pulse, `pass`=1, `fail`=0, `result`=1, `cycles`=6, `m_req` high exactly 2 cycles.
- Same responder with `m_return`=32'h0000_00A5, `expected`=32'h0000_00A4, mask=FFFFFFFF -> `fail`=1, `pass`=0; with `mask`=FFFFFFFE -> `pass`=1.
- `m_busy` already high at `start` and falling 7 cycles later -> `m_req` stays 0 during those 7 cycles, then the call proceeds and `pass`=1.
- Responder never raises `m_busy`, ACK_WAIT=4 -> `m_req` high exactly 4 cycles, then `done`, `timeout`=1, `pass`=0, `fail`=0.
- `m_busy` stuck high after ack, TIMEOUT=50 -> `done` 50 cycles after `start`, `timeout`=1, `m_req` 0.
- `reset` pulsed 3 cycles into RUN -> `m_req`, `busy` and flags are 0 after that edge, no `done`; the next `start` completes normally. Extra `start` pulses during RUN are ignored (exactly one `done`).
